// File: rtl/password_entry.sv
// password_entry: debounced enter/clear front end assembling DIGITS BCD digits.
// Define PASSWORD_ENTRY_TIMEOUT_EN to clear a stale partial entry after TIMEOUT_CYCLES.
module password_entry #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic                  clk,
    input  logic                  rst_a_n,
    input  logic [3:0]            digit_in,
    input  logic                  enter_btn,
    input  logic                  clear_btn,
    output logic [4*DIGITS-1:0]   code_out,
    output logic                  code_valid,
    input  logic                  code_ready,
    output logic [3:0]            digit_count,
    output logic                  digit_err,
    output logic                  timeout_pulse
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Index 0 is enter, index 1 is clear.
    logic [1:0]     btn_raw;
    logic [1:0]     sync1_q;
    logic [1:0]     sync2_q;
    logic [1:0]     deb_q;
    logic [1:0]     deb_d;
    logic [1:0]     press_q;
    logic [1:0]     press_d;
    logic [DBW-1:0] dcnt_q [2];
    logic [DBW-1:0] dcnt_d [2];

    logic [3:0]     dig_s1_q;
    logic [3:0]     dig_s2_q;

    state_t              state_q;
    state_t              state_d;
    logic [4*DIGITS-1:0] code_q;
    logic [4*DIGITS-1:0] code_d;
    logic                valid_q;
    logic                valid_d;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;
    logic                err_q;
    logic                err_d;

    logic ent_stb;
    logic clr_stb;
    logic tmo_hit;

    assign btn_raw = {clear_btn, enter_btn};
    assign ent_stb = press_q[0];
    assign clr_stb = press_q[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]  = deb_q[i];
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DBW'(1);
                end
            end
            press_d[i] = deb_d[i] & ~deb_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            press_q  <= '0;
            dig_s1_q <= '0;
            dig_s2_q <= '0;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            press_q  <= press_d;
            dig_s1_q <= digit_in;
            dig_s2_q <= dig_s1_q;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

`ifdef PASSWORD_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    logic          tmo_pulse_q;
    logic          tmo_run;

    assign tmo_run = (state_q == COLLECT) && (cnt_q != 4'd0);
    assign tmo_hit = tmo_run && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if (tmo_run && !ent_stb && !clr_stb && !tmo_hit) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            tmo_q       <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_q       <= tmo_d;
            tmo_pulse_q <= tmo_hit && !ent_stb && !clr_stb;
        end
    end

    assign timeout_pulse = tmo_pulse_q;
`else
    assign tmo_hit       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // Clear beats enter; either strobe beats an expiring timeout.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (clr_stb) begin
                    code_d = '0;
                    cnt_d  = 4'd0;
                end else if (ent_stb) begin
                    if (dig_s2_q > 4'd9) begin
                        err_d = 1'b1;
                    end else begin
                        code_d = {code_q[4*DIGITS-5:0], dig_s2_q};
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == 4'(DIGITS - 1)) begin
                            state_d = FULL;
                            valid_d = 1'b1;
                        end
                    end
                end else if (tmo_hit) begin
                    code_d = '0;
                    cnt_d  = 4'd0;
                end
            end
            FULL: begin
                if (code_ready) begin
                    state_d = COLLECT;
                    valid_d = 1'b0;
                    code_d  = '0;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q <= COLLECT;
            code_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign code_out    = code_q;
    assign code_valid  = valid_q;
    assign digit_count = cnt_q;
    assign digit_err   = err_q;

endmodule

// File: doc/password_entry.md
Name: password_entry

Overview:
- Input-side front end for the password lock: captures the code the user types on the DE10-Lite switches and buttons, then hands it to the checker.
- Debounces the enter/clear buttons and accepts one BCD digit per enter press.
- Assembles DIGITS digits into a code word and presents it with a valid/ready handshake.
- Also exports progress/error status for the HEX display path.

Parameters:
DIGITS, 4, number of BCD digits per code (2..8)
DEBOUNCE_CYCLES, 500000, stable-level cycles needed to accept a button change (10 ms at 50 MHz); minimum 2
TIMEOUT_CYCLES, 250000000, inactivity limit used only when PASSWORD_ENTRY_TIMEOUT_EN is defined (5 s at 50 MHz)

Ports:
clk  input  1  system clock (50 MHz)
rst_a_n  input  1  asynchronous reset, active-low
digit_in  input  4  BCD digit from switches SW[3:0]; quasi-static
enter_btn  input  1  raw enter button, active-high (wrapper inverts KEY), asynchronous
clear_btn  input  1  raw clear button, active-high, asynchronous
code_out  output  4*DIGITS  assembled code; first digit entered in the MS nibble
code_valid  output  1  code_out holds a complete code
code_ready  input  1  checker accepts the code
digit_count  output  4  digits captured so far (0..DIGITS)
digit_err  output  1  one-cycle pulse: an entered digit was > 9 and was rejected
timeout_pulse  output  1  one-cycle pulse on inactivity clear; tied 0 when the feature is off

Behaviour:
- Reset is asynchronous, active-low and applies immediately.
  - Reset values: code_out=0, code_valid=0, digit_count=0, digit_err=0, timeout_pulse=0.
  - Also cleared on reset: synchronizer flops, debounce counters and debounced levels.
  - FSM returns to COLLECT.
- Input conditioning, per button:
  - 2-FF synchronizer, then debounce counter.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A rising edge of the debounced level produces a one-cycle press strobe.
  - Latency: press strobe occurs DEBOUNCE_CYCLES+3 cycles after a clean raw edge.
- digit_in is sampled through a 2-FF synchronizer and captured on the enter strobe cycle.
- FSM states: COLLECT and FULL.
  - COLLECT, enter strobe with digit <= 9:
    - code_out <= {code_out[4*DIGITS-5:0], digit}; digit_count += 1.
    - If the new count equals DIGITS, go to FULL and assert code_valid on the next cycle, i.e. the same edge as the last shift.
  - COLLECT, enter strobe with digit > 9: digit_err pulses for 1 cycle; code_out and count are unchanged.
  - COLLECT, clear strobe: code_out=0, digit_count=0.
    - Clear and enter strobes in the same cycle: clear wins and the digit is discarded.
  - FULL:
    - code_valid=1; code_out and code_valid stay stable until code_valid && code_ready.
    - On handshake: code_valid=0, code_out=0, digit_count=0, state returns to COLLECT.
    - Enter and clear strobes are ignored in FULL; they are not queued.
  - code_ready while code_valid=0 has no effect.
- Handshake: the transfer occurs on a rising clk edge with code_valid=1 and code_ready=1. The checker may hold ready high permanently, giving a single-cycle valid.
- digit_count never exceeds DIGITS and never wraps.
- Reset asserted mid-entry or in FULL discards the partial or pending code; no handshake completes.

Optional Feature:
- Macro: PASSWORD_ENTRY_TIMEOUT_EN.
- Defined:
  - A counter runs while in COLLECT with digit_count > 0.
  - The counter restarts on every accepted or rejected enter strobe and on clear.
  - When it reaches TIMEOUT_CYCLES: partial entry cleared (code_out=0, digit_count=0) and timeout_pulse high for 1 cycle.
  - The counter is held at 0 in FULL and when the count is 0.
- Not defined: no counter logic is generated; timeout_pulse is constant 0; a partial entry persists indefinitely.

Test Plan:
- Bench setting: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, DIGITS=4, code_ready=0 unless stated.
- Enter digits 1,2,3,4 with clean presses -> code_out=16'h1234 and code_valid=1 after the fourth strobe; digit_count=4. Pulse code_ready for one cycle -> next cycle code_valid=0, code_out=0, digit_count=0.
- Enter with a 3-cycle bounce pattern (1,0,1,1,1,1,1) on digit 7 -> exactly one strobe; digit_count increments by 1; code_out[3:0]=7.
- Enter with digit_in=4'hB -> digit_err pulses for 1 cycle; digit_count is unchanged at its prior value (e.g. 2).
- After entering 5,6: clear and enter strobes in the same cycle -> code_out=0, digit_count=0. Then while in FULL with code 9,8,7,6, press clear and enter -> code_out stays 16'h9876 and code_valid stays 1.
- Assert rst_a_n=0 asynchronously between clock edges during FULL -> code_valid=0 and code_out=0 immediately. With PASSWORD_ENTRY_TIMEOUT_EN, enter one digit then idle 50 cycles -> timeout_pulse for 1 cycle, digit_count=0.
